// File: rtl/demux14_pkg.sv
// Shared types and defaults for the 1-to-4 demultiplexing dispatcher.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package demux14_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  // Index of one of the four output slots.
  typedef logic [1:0] slot_idx_t;

  localparam slot_idx_t SLOT0 = 2'd0;
  localparam slot_idx_t SLOT1 = 2'd1;
  localparam slot_idx_t SLOT2 = 2'd2;
  localparam slot_idx_t SLOT3 = 2'd3;

endpackage

// File: rtl/demux14_slot.sv
// One-entry holding register with a valid flag, feeding one consumer.
// Latency: a loaded word is visible on data/valid one cycle after load.
// Backpressure: the word is held until drain; load in the same cycle as drain replaces it with no bubble.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        capture load_data this edge (wins over drain)
//   load_data   word to capture
//   drain       consumer takes the held word this edge
//   data        held word (stale while valid=0)
//   valid       slot holds an undelivered word
module demux14_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      // A load covers the simultaneous drain+refill case: valid stays high.
      data  <= load_data;
      valid <= 1'b1;
    end else if (drain) begin
      // Data is left stale; it is don't-care once valid drops.
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux14_dispatcher.sv
// 1-to-4 demultiplexer: routes each producer word into one of four registered slots.
// Latency: one cycle from accept to the word appearing on oYk with oValid[k] set.
// Backpressure: oReady follows the selected slot only (free, or draining this cycle).
//
// Ports:
//   iClk, iRst_n    clock and asynchronous active-low reset
//   iD, iValid      producer word and its valid; iS1/iS0 select the slot
//   oReady          selected slot can accept this cycle (combinational)
//   oY0..oY3        slot data registers; oValid[k] marks slot k occupied
//   iReady[k]       consumer k takes oYk this cycle
//   oAccCnt         wrapping count of accepted words
//   oPtr            round-robin pointer (only with DEMUX14_RR_EN)
//
// Build option DEMUX14_RR_EN: a round-robin pointer that advances on every
// accept replaces the iS1/iS0 select, and is exposed on oPtr.
module demux14_dispatcher
  import demux14_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [WIDTH-1:0] iD,
  input  logic             iS0,
  input  logic             iS1,
  input  logic             iValid,
  output logic             oReady,
  output logic [WIDTH-1:0] oY0,
  output logic [WIDTH-1:0] oY1,
  output logic [WIDTH-1:0] oY2,
  output logic [WIDTH-1:0] oY3,
  output logic [3:0]       oValid,
  input  logic [3:0]       iReady,
  output logic [CNT_W-1:0] oAccCnt
`ifdef DEMUX14_RR_EN
  ,
  output logic [1:0]       oPtr
`endif
);

  slot_idx_t        sel;
  logic             accept;
  logic [3:0]       load_vec;
  logic [3:0]       drain_vec;
  logic [WIDTH-1:0] slot_data [4];

`ifdef DEMUX14_RR_EN
  slot_idx_t ptr;
  logic      unused_sel;

  // Select inputs are ignored when the pointer does the routing.
  assign unused_sel = iS0 ^ iS1;
  assign sel        = ptr;
  assign oPtr       = ptr;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      ptr <= SLOT0;
    end else if (accept) begin
      ptr <= ptr + 2'd1;
    end
  end
`else
  assign sel = {iS1, iS0};
`endif

  // A full slot can still accept when its consumer drains it this cycle.
  assign oReady = ~oValid[sel] | iReady[sel];
  assign accept = iValid & oReady;

  always_comb begin
    load_vec = 4'b0000;
    case (sel)
      SLOT0:   load_vec[0] = accept;
      SLOT1:   load_vec[1] = accept;
      SLOT2:   load_vec[2] = accept;
      SLOT3:   load_vec[3] = accept;
      default: load_vec    = 4'b0000;
    endcase
  end

  // iReady on an empty slot is harmless; a same-slot load overrides the drain.
  assign drain_vec = oValid & iReady & ~load_vec;

  for (genvar k = 0; k < 4; k++) begin : g_slot
    demux14_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk       (iClk),
      .rst_n     (iRst_n),
      .load      (load_vec[k]),
      .load_data (iD),
      .drain     (drain_vec[k]),
      .data      (slot_data[k]),
      .valid     (oValid[k])
    );
  end

  assign oY0 = slot_data[0];
  assign oY1 = slot_data[1];
  assign oY2 = slot_data[2];
  assign oY3 = slot_data[3];

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oAccCnt <= '0;
    end else if (accept) begin
      oAccCnt <= oAccCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux14_dispatcher.sv
// Self-checking bench for demux14_dispatcher: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// slot-occupancy model.
module tb_demux14_dispatcher;

  logic       iClk   = 1'b0;
  logic       iRst_n = 1'b0;
  logic [3:0] iD     = 4'h0;
  logic       iS0    = 1'b0;
  logic       iS1    = 1'b0;
  logic       iValid = 1'b0;
  logic [3:0] iReady = 4'h0;
  logic       oReady;
  logic [3:0] oY0, oY1, oY2, oY3;
  logic [3:0] oValid;
  logic [7:0] oAccCnt;
`ifdef DEMUX14_RR_EN
  logic [1:0] oPtr;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: contents and occupancy of each slot, accept count, pointer.
  logic [3:0] m_y [4];
  logic [3:0] m_v;
  logic [7:0] m_cnt;
  logic [1:0] m_ptr;
  bit         m_acc;

  demux14_dispatcher #(.WIDTH(4), .CNT_W(8)) dut (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iD      (iD),
    .iS0     (iS0),
    .iS1     (iS1),
    .iValid  (iValid),
    .oReady  (oReady),
    .oY0     (oY0),
    .oY1     (oY1),
    .oY2     (oY2),
    .oY3     (oY3),
    .oValid  (oValid),
    .iReady  (iReady),
    .oAccCnt (oAccCnt)
`ifdef DEMUX14_RR_EN
    ,
    .oPtr    (oPtr)
`endif
  );

  initial forever #5 iClk = ~iClk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
  endtask

  function automatic logic [3:0] y_of(input int k);
    case (k)
      0:       return oY0;
      1:       return oY1;
      2:       return oY2;
      default: return oY3;
    endcase
  endfunction

  function automatic int m_sel();
`ifdef DEMUX14_RR_EN
    return int'(m_ptr);
`else
    return int'({iS1, iS0});
`endif
  endfunction

  // Model update on every edge (and immediately on reset assertion).
  initial begin
    int s;
    bit acc;
    m_v = 4'h0; m_cnt = 8'h0; m_ptr = 2'd0; m_acc = 1'b0;
    for (int k = 0; k < 4; k++) m_y[k] = 4'h0;
    forever begin
      @(posedge iClk or negedge iRst_n);
      if (!iRst_n) begin
        m_v = 4'h0; m_cnt = 8'h0; m_ptr = 2'd0; m_acc = 1'b0;
        for (int k = 0; k < 4; k++) m_y[k] = 4'h0;
      end else begin
        s   = m_sel();
        acc = iValid && (!m_v[s] || iReady[s]);
        m_v = m_v & ~iReady;          // every ready consumer empties its slot
        if (acc) begin
          m_y[s] = iD;
          m_v[s] = 1'b1;
          m_cnt  = m_cnt + 8'd1;
          m_ptr  = m_ptr + 2'd1;
        end
        m_acc = acc;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge iClk);
    if (cmp_en && iRst_n) begin
      chk("valid", 32'(oValid), 32'(m_v));
      chk("acc_cnt", 32'(oAccCnt), 32'(m_cnt));
      chk("ready", 32'(oReady), 32'(!m_v[m_sel()] || iReady[m_sel()]));
      for (int k = 0; k < 4; k++)
        if (m_v[k]) chk("slot_data", 32'(y_of(k)), 32'(m_y[k]));
`ifdef DEMUX14_RR_EN
      chk("ptr", 32'(oPtr), 32'(m_ptr));
`endif
    end
  end

  // Present inputs, let one edge happen, return at negedge+1.
  task automatic drive(input bit v, input logic [1:0] s, input logic [3:0] d, input logic [3:0] r);
    iValid = v; {iS1, iS0} = s; iD = d; iReady = r;
    @(negedge iClk); #1;
  endtask

  // Present inputs and check the combinational ready before the edge.
  task automatic present(input bit v, input logic [1:0] s, input logic [3:0] d, input logic [3:0] r,
                         input bit exp_rdy, input string name);
    iValid = v; {iS1, iS0} = s; iD = d; iReady = r;
    #1;
    chk(name, 32'(oReady), 32'(exp_rdy));
    @(negedge iClk); #1;
  endtask

  task automatic reset_pulse();
    iValid = 1'b0; iReady = 4'h0;
    iRst_n = 1'b0;
    @(negedge iClk); #1;
    iRst_n = 1'b1;
  endtask

  initial begin
    bit         v;
    logic [1:0] s;
    logic [3:0] d;
    logic [3:0] r;

    repeat (2) @(negedge iClk);
    #1;
    chk("reset_valid", 32'(oValid), 32'h0);
    chk("reset_cnt", 32'(oAccCnt), 32'h0);
    chk("reset_y0", 32'(oY0), 32'h0);
    iRst_n = 1'b1;
    cmp_en = 1'b1;

`ifndef DEMUX14_RR_EN
    // Routing sweep: one word per slot, every consumer always ready.
    for (int i = 0; i < 4; i++) begin
      d = 4'h1 << i;
      s = 2'(i);
      drive(1'b1, s, d, 4'hF);
      chk("sweep_valid_pulse", 32'(oValid), 32'(4'h1 << i));
      chk("sweep_data", 32'(y_of(i)), 32'(d));
    end
    drive(1'b0, 2'd0, 4'h0, 4'hF);
    chk("sweep_y0", 32'(oY0), 32'h1);
    chk("sweep_y1", 32'(oY1), 32'h2);
    chk("sweep_y2", 32'(oY2), 32'h4);
    chk("sweep_y3", 32'(oY3), 32'h8);
    chk("sweep_valid_idle", 32'(oValid), 32'h0);
    chk("sweep_cnt", 32'(oAccCnt), 32'd4);

    // Backpressure on slot 1.
    drive(1'b1, 2'd1, 4'hA, 4'h0);
    chk("bp_valid", 32'(oValid), 32'h2);
    chk("bp_y1_first", 32'(oY1), 32'hA);
    present(1'b1, 2'd1, 4'h5, 4'h0, 1'b0, "bp_ready_low");
    chk("bp_y1_held", 32'(oY1), 32'hA);
    chk("bp_cnt_held", 32'(oAccCnt), 32'd5);
    present(1'b1, 2'd1, 4'h5, 4'h2, 1'b1, "bp_ready_drain");
    chk("bp_y1_new", 32'(oY1), 32'h5);
    chk("bp_valid_kept", 32'(oValid), 32'h2);
    chk("bp_cnt", 32'(oAccCnt), 32'd6);

    // Independence: slot 2 stalled, slot 0 still accepts.
    drive(1'b1, 2'd2, 4'h7, 4'h0);
    drive(1'b1, 2'd0, 4'h3, 4'h0);
    chk("ind_y0", 32'(oY0), 32'h3);
    chk("ind_y2", 32'(oY2), 32'h7);
    chk("ind_valid", 32'(oValid), 32'h7);
    drive(1'b0, 2'd0, 4'h0, 4'h2);
    chk("pre_reset_valid", 32'(oValid), 32'h5);

    // Asynchronous reset mid-run, checked before any edge.
    iRst_n = 1'b0;
    #1;
    chk("async_valid", 32'(oValid), 32'h0);
    chk("async_cnt", 32'(oAccCnt), 32'h0);
    chk("async_y", 32'({oY0, oY1, oY2, oY3}), 32'h0);
    @(negedge iClk); #1;
    iRst_n = 1'b1;
`endif

    // Counter wrap after 256 accepts from zero.
    reset_pulse();
    for (int i = 1; i <= 256; i++) begin
      drive(1'b1, 2'($urandom), 4'($urandom), 4'hF);
      if (i == 255) chk("wrap_255", 32'(oAccCnt), 32'd255);
      if (i == 256) chk("wrap_0", 32'(oAccCnt), 32'd0);
    end

`ifdef DEMUX14_RR_EN
    // Round-robin: select held at 11, captures rotate through the slots.
    reset_pulse();
    for (int i = 0; i < 5; i++) begin
      d = 4'(i + 1);
      drive(1'b1, 2'd3, d, 4'hF);
      chk("rr_valid", 32'(oValid), 32'(4'h1 << (i % 4)));
      chk("rr_data", 32'(y_of(i % 4)), 32'(d));
    end
    chk("rr_ptr", 32'(oPtr), 32'd1);
    repeat (3) drive(1'b0, 2'd3, 4'h0, 4'hF);
    chk("rr_ptr_idle", 32'(oPtr), 32'd1);
`endif

    // Randomized traffic; producer holds word/select while stalled.
    reset_pulse();
    v = 1'b0; s = 2'd0; d = 4'h0;
    repeat (3000) begin
      if (!(v && !m_acc)) begin
        v = ($urandom_range(0, 3) != 0);
        s = 2'($urandom);
        d = 4'($urandom);
      end
      r = 4'($urandom) & 4'($urandom | $urandom);
      drive(v, s, d, r);
    end

    // Mid-traffic reset with a model cross-check on the first cycle after.
    iRst_n = 1'b0;
    #1;
    chk("final_reset_valid", 32'(oValid), 32'h0);
    @(negedge iClk); #1;
    iRst_n = 1'b1;
    drive(1'b1, 2'd2, 4'h9, 4'h0);
    chk("post_reset_cnt", 32'(oAccCnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
